// File: rtl/cordic_vec_demod.sv
// Iterative vectoring-mode CORDIC: magnitude, phase and sample-to-sample
// phase difference (FM discriminator) of a complex I/Q stream.
module cordic_vec_demod #(
  parameter int BW   = 12,
  parameter int ABW  = 10,
  parameter int ITER = 8
) (
  input  logic                  clk_fs,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [BW-1:0]  i_in,
  input  logic signed [BW-1:0]  q_in,
  output logic                  out_valid,
  output logic [BW:0]           mag,
  output logic [ABW-1:0]        phase,
  output logic [ABW-1:0]        dphase,
  output logic                  overflow
);

  localparam int XW = BW + 2;
  localparam int IW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_OUT
  } state_t;

  // atan(2^-k) as a fraction of a circle, held at 2^24 and rounded to ABW
  function automatic logic [ABW-1:0] atan_lut(input logic [IW-1:0] k);
    longint v;
    int     kk;
    v  = 0;
    kk = int'(k);
    case (kk)
      0:       v = 2097152;
      1:       v = 1238021;
      2:       v = 654136;
      3:       v = 332050;
      4:       v = 166669;
      5:       v = 83416;
      6:       v = 41718;
      7:       v = 20860;
      8:       v = 10430;
      9:       v = 5215;
      10:      v = 2608;
      11:      v = 1304;
      12:      v = 652;
      13:      v = 326;
      14:      v = 163;
      15:      v = 81;
      default: v = 0;
    endcase
    v = (v + (longint'(1) << (23 - ABW))) >>> (24 - ABW);
    return ABW'(v);
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic signed [XW-1:0]  r_x;
  logic signed [XW-1:0]  r_y;
  logic [ABW-1:0]        r_z;
  logic [IW-1:0]         r_iter;
  logic                  r_zero;
  logic [ABW-1:0]        r_prev;
  logic                  r_vld_d;

  logic signed [XW-1:0]  w_ie;
  logic signed [XW-1:0]  w_qe;
  logic signed [XW-1:0]  w_xs;
  logic signed [XW-1:0]  w_ys;
  logic [ABW-1:0]        w_atan;
  logic [ABW-1:0]        w_ph;
  logic                  w_last;

  assign w_ie   = {{2{i_in[BW-1]}}, i_in};
  assign w_qe   = {{2{q_in[BW-1]}}, q_in};
  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_atan = atan_lut(r_iter);
  assign w_ph   = r_zero ? '0 : r_z;
  assign w_last = (r_iter == IW'(ITER - 1));

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ROT;
      end
      S_ROT:   if (w_last) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_iter    <= '0;
      r_zero    <= 1'b0;
      r_prev    <= '0;
      r_vld_d   <= 1'b0;
      out_valid <= 1'b0;
      mag       <= '0;
      phase     <= '0;
      dphase    <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      r_vld_d   <= in_valid;
      // a held strobe waits for ready; only a fresh strobe while busy is lost
      if (in_valid && !r_vld_d && !in_ready) overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_ie[XW-1]) begin
              r_x <= -w_ie;
              r_y <= -w_qe;
              r_z <= {1'b1, {(ABW-1){1'b0}}};
            end else begin
              r_x <= w_ie;
              r_y <= w_qe;
              r_z <= '0;
            end
            r_zero <= (i_in == '0) && (q_in == '0);
            r_iter <= '0;
          end
        end
        S_ROT: begin
          if (!r_y[XW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          r_iter <= r_iter + 1'b1;
        end
        S_OUT: begin
          mag       <= r_zero ? '0 : r_x[BW:0];
          phase     <= w_ph;
          dphase    <= w_ph - r_prev;
          r_prev    <= w_ph;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec_demod.sv
// Bench for cordic_vec_demod: directed quadrant/handshake/reset cases plus
// random samples against ideal atan2/hypot arithmetic.
module tb_cordic_vec_demod;

  localparam int BW   = 12;
  localparam int ABW  = 10;
  localparam int ITER = 8;
  localparam real PI  = 3.14159265358979;
  localparam real K   = 1.6468;

  logic                 clk_fs = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [BW-1:0] i_in = '0;
  logic signed [BW-1:0] q_in = '0;
  logic                 out_valid;
  logic [BW:0]          mag;
  logic [ABW-1:0]       phase;
  logic [ABW-1:0]       dphase;
  logic                 overflow;

  int checks = 0;
  int failures = 0;

  cordic_vec_demod #(.BW(BW), .ABW(ABW), .ITER(ITER)) dut (
    .clk_fs    (clk_fs),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_in      (i_in),
    .q_in      (q_in),
    .out_valid (out_valid),
    .mag       (mag),
    .phase     (phase),
    .dphase    (dphase),
    .overflow  (overflow)
  );

  always #5 clk_fs = ~clk_fs;

  function automatic real ideal_phase(input int i, input int q);
    real a;
    a = $atan2(real'(q), real'(i));
    if (a < 0.0) a = a + 2.0 * PI;
    return a * 1024.0 / (2.0 * PI);
  endfunction

  function automatic real ideal_mag(input int i, input int q);
    return K * $sqrt(real'(i * i + q * q));
  endfunction

  function automatic real cdiff(input int obs, input real ideal);
    real d;
    d = real'(obs) - ideal;
    while (d >= 512.0) d = d - 1024.0;
    while (d < -512.0) d = d + 1024.0;
    return d;
  endfunction

  task automatic pick(output int i, output int q);
    do begin
      i = int'($urandom_range(0, 4095)) - 2048;
      q = int'($urandom_range(0, 4095)) - 2048;
    end while (i * i + q * q < 262144);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk_fs);
    @(negedge clk_fs);
    rst = 1'b0;
  endtask

  task automatic send(input int i, input int q, output int lat,
                      output int m, output int p, output int dp);
    @(negedge clk_fs);
    i_in = BW'(i);
    q_in = BW'(q);
    in_valid = 1'b1;
    @(posedge clk_fs);
    #1 in_valid = 1'b0;
    lat = -1; m = -1; p = -1; dp = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_fs);
      #1;
      if (out_valid) begin
        lat = n; m = int'(mag); p = int'(phase); dp = int'(dphase);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rdy=%b ov=%b of=%b exp 1 0 0",
               in_ready, out_valid, overflow);
    end
    checks++;
    if (mag !== '0 || phase !== '0 || dphase !== '0) begin
      failures++;
      $display("FAIL reset_data got mag=%0d ph=%0d dph=%0d exp 0 0 0",
               mag, phase, dphase);
    end
    do_reset();
  endtask

  task automatic test_quadrants();
    int ti[5] = '{1000, 0, -1000, 0, -2048};
    int tq[5] = '{0, 1000, 0, -1000, -2048};
    int ep[5] = '{0, 256, 512, 768, 640};
    int em[5] = '{1646, 1646, 1646, 1646, 4770};
    int mt[5] = '{4, 4, 4, 4, 6};
    int lat, m, p, dp;
    real d;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(ti[k], tq[k], lat, m, p, dp);
      checks++;
      if (lat !== ITER + 1) begin
        failures++;
        $display("FAIL quad%0d_latency got=%0d exp=%0d", k, lat, ITER + 1);
      end
      d = cdiff(p, real'(ep[k]));
      checks++;
      if (d > 2.0 || d < -2.0) begin
        failures++;
        $display("FAIL quad%0d_phase got=%0d exp=%0d+-2", k, p, ep[k]);
      end
      checks++;
      if (m > em[k] + mt[k] || m < em[k] - mt[k]) begin
        failures++;
        $display("FAIL quad%0d_mag got=%0d exp=%0d+-%0d", k, m, em[k], mt[k]);
      end
    end
  endtask

  task automatic test_zero();
    int lat, m, p, dp;
    send(0, 0, lat, m, p, dp);
    checks++;
    if (lat !== ITER + 1 || m !== 0 || p !== 0) begin
      failures++;
      $display("FAIL zero got lat=%0d mag=%0d ph=%0d exp %0d 0 0",
               lat, m, p, ITER + 1);
    end
  endtask

  task automatic test_dphase();
    int lat, m, p0, p1, p2, d0, d1, d2, e;
    real d;
    do_reset();
    send(0, 1000, lat, m, p0, d0);
    checks++;
    if (d0 !== p0 || d0 > 258 || d0 < 254) begin
      failures++;
      $display("FAIL dph0 got=%0d exp=%0d (256+-2)", d0, p0);
    end
    send(0, -1000, lat, m, p1, d1);
    e = (p1 - p0) & 1023;
    checks++;
    if (d1 !== e || d1 > 516 || d1 < 508) begin
      failures++;
      $display("FAIL dph1 got=%0d exp=%0d (512+-4)", d1, e);
    end
    send(1000, 0, lat, m, p2, d2);
    e = (p2 - p1) & 1023;
    d = cdiff(d2, 256.0);
    checks++;
    if (d2 !== e || d > 4.0 || d < -4.0) begin
      failures++;
      $display("FAIL dph2 got=%0d exp=%0d (256+-4)", d2, e);
    end
  endtask

  task automatic test_back_to_back();
    int si, sq, nout, bad;
    int acc[$];
    logic rb, er;
    real d;
    do_reset();
    pick(si, sq);
    nout = 0; bad = 0;
    @(negedge clk_fs);
    i_in = BW'(si);
    q_in = BW'(sq);
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rb = in_ready;
      @(posedge clk_fs);
      #1;
      if (rb) acc.push_back(k);
      er = ((k % (ITER + 2)) == ITER + 1);
      if (in_ready !== er) bad++;
      if (out_valid) begin
        nout++;
        d = cdiff(int'(phase), ideal_phase(si, sq));
        checks++;
        if (d > 3.0 || d < -3.0) begin
          failures++;
          $display("FAIL b2b_phase got=%0d exp=%0f", phase, ideal_phase(si, sq));
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc.size() != 4 || acc[0] != 0 || acc[1] != 10 ||
        acc[2] != 20 || acc[3] != 30) begin
      failures++;
      $display("FAIL b2b_accepts got n=%0d exp edges 0,10,20,30", acc.size());
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL b2b_ready got=%0d bad cycles exp=0", bad);
    end
    checks++;
    if (nout !== 4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_out got n=%0d of=%b exp n=4 of=0", nout, overflow);
    end
    repeat (12) @(posedge clk_fs);
  endtask

  task automatic test_overflow();
    int lat, m, p, dp, extra;
    real d;
    do_reset();
    @(negedge clk_fs);
    i_in = BW'(0);
    q_in = BW'(1000);
    in_valid = 1'b1;
    @(posedge clk_fs);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk_fs);
    #1;
    i_in = BW'(-1000);
    q_in = BW'(0);
    in_valid = 1'b1;
    @(posedge clk_fs);
    #1 in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    lat = -1; p = -1;
    for (int n = 4; n <= 20; n++) begin
      @(posedge clk_fs);
      #1;
      if (out_valid) begin
        lat = n; p = int'(phase);
        break;
      end
    end
    d = cdiff(p, 256.0);
    checks++;
    if (lat !== ITER + 1 || d > 2.0 || d < -2.0) begin
      failures++;
      $display("FAIL ovf_first got lat=%0d ph=%0d exp %0d 256", lat, p, ITER + 1);
    end
    extra = 0;
    repeat (15) begin
      @(posedge clk_fs);
      #1;
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ovf_dropped got=%0d results exp=0", extra);
    end
    send(-1000, 0, lat, m, p, dp);
    d = cdiff(p, 512.0);
    checks++;
    if (overflow !== 1'b1 || d > 2.0 || d < -2.0) begin
      failures++;
      $display("FAIL ovf_sticky got of=%b ph=%0d exp 1 512", overflow, p);
    end
  endtask

  task automatic test_reset_mid();
    int lat, m, p, dp, extra;
    real d;
    do_reset();
    send(1000, 1000, lat, m, p, dp);
    @(negedge clk_fs);
    i_in = BW'(0);
    q_in = BW'(-1000);
    in_valid = 1'b1;
    @(posedge clk_fs);
    #1 in_valid = 1'b0;
    @(posedge clk_fs);
    #1 in_valid = 1'b1;
    @(posedge clk_fs);
    #1 in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || mag === '0) begin
      failures++;
      $display("FAIL rmid_pre got of=%b mag=%0d exp 1 nonzero", overflow, mag);
    end
    repeat (2) @(posedge clk_fs);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (mag !== '0 || phase !== '0 || dphase !== '0 || overflow !== 1'b0 ||
        in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_clear got mag=%0d ph=%0d dph=%0d of=%b rdy=%b exp 0 0 0 0 1",
               mag, phase, dphase, overflow, in_ready);
    end
    @(negedge clk_fs);
    rst = 1'b0;
    extra = 0;
    repeat (15) begin
      @(posedge clk_fs);
      #1;
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL rmid_noout got=%0d results exp=0", extra);
    end
    send(0, 1000, lat, m, p, dp);
    d = cdiff(p, 256.0);
    checks++;
    if (lat !== ITER + 1 || d > 2.0 || d < -2.0 || dp !== p) begin
      failures++;
      $display("FAIL rmid_next got lat=%0d ph=%0d dph=%0d exp %0d 256 =ph",
               lat, p, dp, ITER + 1);
    end
  endtask

  task automatic test_random();
    int si, sq, lat, m, p, dp, prev, e;
    real d, dm;
    do_reset();
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      pick(si, sq);
      send(si, sq, lat, m, p, dp);
      d  = cdiff(p, ideal_phase(si, sq));
      dm = real'(m) - ideal_mag(si, sq);
      e  = (p - prev) & 1023;
      checks++;
      if (lat !== ITER + 1 || d > 3.0 || d < -3.0 || dm > 6.0 || dm < -6.0) begin
        failures++;
        $display("FAIL rand%0d (%0d,%0d) got lat=%0d ph=%0d mag=%0d exp ph=%0f mag=%0f",
                 k, si, sq, lat, p, m, ideal_phase(si, sq), ideal_mag(si, sq));
      end
      checks++;
      if (dp !== e) begin
        failures++;
        $display("FAIL rand%0d_dph got=%0d exp=%0d", k, dp, e);
      end
      prev = p;
    end
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_zero();
    test_dphase();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_vec_demod.md
Name: cordic_vec_demod

Overview:
Downstream consumer of the frequency down-converter's decimated I/Q output. Each accepted complex sample goes through an iterative (one micro-rotation per clock) CORDIC in vectoring mode, which produces magnitude and phase. The block also produces the sample-to-sample phase difference, which serves as an FM discriminator. Angle format is the codebase convention: an unsigned ABW-bit fraction of a full circle (2^(ABW-1) = pi).

Parameters:
BW, 12, input I/Q width (two's complement)
ABW, 10, angle width (fraction of circle)
ITER, 8, micro-rotations per sample (1..ABW-2)

Ports:
clk_fs  in  1  processing clock
rst  in  1  reset
in_valid  in  1  input sample strobe
in_ready  out  1  high when the block can accept a sample
i_in  in  BW  I sample, signed
q_in  in  BW  Q sample, signed
out_valid  out  1  one-cycle result strobe
mag  out  BW+1  unsigned magnitude, CORDIC gain K is not compensated
phase  out  ABW  atan2(Q,I), fraction of circle
dphase  out  ABW  phase minus previous phase, mod 2^ABW
overflow  out  1  sticky: a sample was offered while busy

Behaviour:
- Interface: single clock clk_fs; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, mag=0, phase=0, dphase=0, prev_phase=0, overflow=0.
- Internal width XW=BW+2. Inputs are sign-extended to XW. The z register is ABW bits and wraps mod 2^ABW.
- Angle table: atan_i = round(atan(2^-i)*2^ABW/(2*pi)). For ABW=10 the table is 128, 76, 40, 20, 10, 5, 3, 1.
- FSM IDLE:
  - in_ready=1.
  - On the edge with in_valid=1, the sample is accepted and pre-rotated.
  - If i<0: x=-i, y=-q, z=2^(ABW-1). Otherwise: x=i, y=q, z=0.
  - A zero flag is latched when i==0 and q==0.
  - iter=0, then go to ROT.
- FSM ROT:
  - in_ready=0.
  - Each edge performs one micro-rotation, using arithmetic shifts and the old x/y on the right-hand side.
  - If y>=0: x+=y>>>iter, y-=x>>>iter, z+=atan_iter.
  - Otherwise: x-=y>>>iter, y+=x>>>iter, z-=atan_iter.
  - After iteration ITER-1, go to OUT.
- FSM OUT (one cycle, in_ready=0). On its closing edge:
  - mag=x[BW:0]; phase=z, or 0 if the zero flag is set; mag=0 if the zero flag is set.
  - dphase=phase_new-prev_phase mod 2^ABW; prev_phase=phase_new.
  - out_valid=1 for the following single cycle; state returns to IDLE.
- Latency: accept edge E0; out_valid is high in the cycle after edge E(ITER+1).
- Throughput: one sample per ITER+2 cycles. With in_valid held high, accepts occur every ITER+2 edges. The next accept can coincide with the out_valid cycle.
- Input rate from upstream must be ≤ clk_fs/(ITER+2).
- Busy collision: in_valid=1 while in_ready=0 drops that sample and sets overflow. overflow stays set until rst. It never blocks or corrupts the sample in flight.
- Range:
  - -2^(BW-1) inputs negate without overflow in XW.
  - Maximum x ≈ 1.647*sqrt(2)*2^(BW-1), which is < 2^(BW+1), so mag never wraps.
- Accuracy: phase within ±2 LSB of ideal; mag within ±4 of K*|IQ| (K=1.6468 for ITER=8).
- dphase for the first result after reset is relative to prev_phase=0.
- Reset mid-ROT/OUT: the sample is discarded. No out_valid is produced after release. prev_phase and overflow are cleared.

Test Plan:
- I=1000,Q=0 -> out_valid exactly 9 edges after accept; mag 1646±4; phase 0±2 mod 1024.
- Quadrants, one at a time:
  - (0,1000) -> phase 256±2.
  - (-1000,0) -> phase 512±2.
  - (0,-1000) -> phase 768±2.
  - (-2048,-2048) -> phase 640±2, mag 4770±6.
  - Each case gives mag 1646±4 where |IQ|=1000.
- I=0,Q=0 -> mag 0, phase 0 exactly.
- Sequence (0,1000),(0,-1000),(1000,0) -> dphase 256±2 (vs reset 0), then exactly phase1-phase0 (≈512), then ≈256±4 with exact mod-1024 difference.
- in_valid held high for 40 cycles -> accepts at edges 0,10,20,30; in_ready low 9 cycles each; overflow stays 0.
- Handshake fault: in_valid pulsed at edge 3 after an accept -> that sample is dropped, overflow=1 and sticky, first result unaffected.
- Reset fault: rst asserted asynchronously mid-ROT (edge 4) -> outputs 0 immediately, in_ready=1, no out_valid after release, next sample processed normally.
